// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: an in-order circular buffer of {pc, inst}
// pairs with valid/ready handshakes on both sides and a single-cycle flush.
module if_id_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t             entry_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Ready is built only from registered state plus rst/flush, so fetch never
    // sees a combinational path from the decode side's out_ready.
    assign in_ready  = !rst && !flush && !full;
    assign out_valid = !flush && !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // No bypass: a pair pushed into an empty queue shows up one cycle later.
    assign out_pc   = entry_q[rd_ptr].pc;
    assign out_inst = entry_q[rd_ptr].inst;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // NOTE: the storage array is reset on purpose so out_pc/out_inst read 0
    // after reset; flush leaves contents alone because they are don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else if (push) begin
            entry_q[wr_ptr] <= '{pc: in_pc, inst: in_inst};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, streaming
// sequence, and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [$clog2(DEPTH):0] count;

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an ordered list of accepted pairs, head at index 0.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    pair_t model_q[$];
    bit    model_check;

    // One clock cycle: drive inputs, check combinational outputs before the
    // edge, advance the model at the edge, check registered count after it.
    task automatic cycle(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                         input logic [31:0] inst, input bit ordy);
        bit exp_ir, exp_ov, do_push, do_pop;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        exp_ir = !r && !f && (model_q.size() < DEPTH);
        exp_ov = !f && (model_q.size() != 0);
        @(negedge clk);
        if (model_check) begin
            check("model in_ready", 32'(in_ready), 32'(exp_ir));
            check("model out_valid", 32'(out_valid), 32'(exp_ov));
            check("model count", 32'(count), 32'(model_q.size()));
            if (model_q.size() != 0) begin
                check("model out_pc", out_pc, model_q[0].pc);
                check("model out_inst", out_inst, model_q[0].inst);
            end
        end
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            do_push = iv && exp_ir;
            do_pop  = exp_ov && ordy;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: pc, inst: inst});
        end
        #1;
        if (model_check) check("model count after edge", 32'(count), 32'(model_q.size()));
    endtask

    typedef struct {
        string       name;
        bit          rst;
        bit          flush;
        bit          in_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        bit          out_ready;
        bit          e_in_ready;
        bit          e_out_valid;
        bit          chk_pc;
        logic [31:0] e_out_pc;
        int          e_count_before;
        int          e_count_after;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        model_check = 1'b0;

        // First reset edge establishes known state; nothing is checked yet.
        @(posedge clk); #1;
        model_q.delete();

        //               name             rst f iv pc          inst         ordy ir ov chk pc      cb ca
        vecs.push_back('{"reset hold",      1, 0, 1, 32'h40,  32'h0,        1,  0, 0, 1, 32'h0,   0, 0});
        vecs.push_back('{"fill pc0",        0, 0, 1, 32'h0,   32'h00000013, 0,  1, 0, 1, 32'h0,   0, 1});
        vecs.push_back('{"fill pc4",        0, 0, 1, 32'h4,   32'h00100093, 0,  1, 1, 1, 32'h0,   1, 2});
        vecs.push_back('{"full hold",       0, 0, 1, 32'h8,   32'h00200113, 0,  0, 1, 1, 32'h0,   2, 2});
        vecs.push_back('{"full pop",        0, 0, 1, 32'h8,   32'h00200113, 1,  0, 1, 1, 32'h0,   2, 1});
        vecs.push_back('{"push after full", 0, 0, 1, 32'h8,   32'h00200113, 0,  1, 1, 1, 32'h4,   1, 2});
        vecs.push_back('{"flush",           0, 1, 1, 32'hC,   32'h00300193, 1,  0, 0, 1, 32'h4,   2, 0});
        vecs.push_back('{"push post flush", 0, 0, 1, 32'h200, 32'h00400213, 0,  1, 0, 0, 32'h0,   0, 1});
        vecs.push_back('{"pop post flush",  0, 0, 0, 32'h0,   32'h0,        1,  1, 1, 1, 32'h200, 1, 0});
        vecs.push_back('{"push pre rst",    0, 0, 1, 32'h300, 32'h00500293, 0,  1, 0, 0, 32'h0,   0, 1});
        vecs.push_back('{"rst mid op",      1, 0, 0, 32'h0,   32'h0,        0,  0, 1, 1, 32'h300, 1, 0});
        vecs.push_back('{"after rst",       0, 0, 0, 32'h0,   32'h0,        0,  1, 0, 1, 32'h0,   0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_pc     = vecs[i].pc;
            in_inst   = vecs[i].inst;
            out_ready = vecs[i].out_ready;
            @(negedge clk);
            check({vecs[i].name, " in_ready"}, 32'(in_ready), 32'(vecs[i].e_in_ready));
            check({vecs[i].name, " out_valid"}, 32'(out_valid), 32'(vecs[i].e_out_valid));
            check({vecs[i].name, " count"}, 32'(count), 32'(vecs[i].e_count_before));
            if (vecs[i].chk_pc) check({vecs[i].name, " out_pc"}, out_pc, vecs[i].e_out_pc);
            @(posedge clk); #1;
            check({vecs[i].name, " count after"}, 32'(count), 32'(vecs[i].e_count_after));
        end
        model_q.delete();

        // Streaming: both sides always ready/valid, one pair per cycle.
        for (int i = 0; i < 9; i++) begin
            logic [31:0] pc;
            pc = 32'h100 + 32'(4 * i);
            in_valid  = (i < 8);
            in_pc     = pc;
            in_inst   = 32'h13 + 32'(i);
            out_ready = 1'b1;
            rst = 1'b0; flush = 1'b0;
            @(negedge clk);
            if (i < 8) check("stream in_ready", 32'(in_ready), 32'd1);
            check("stream out_valid", 32'(out_valid), 32'(i > 0));
            if (i > 0) begin
                check("stream out_pc", out_pc, 32'h100 + 32'(4 * (i - 1)));
                check("stream out_inst", out_inst, 32'h13 + 32'(i - 1));
            end
            @(posedge clk); #1;
            check("stream count", 32'(count), (i < 8) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the reference model; rare flush and rst.
        model_q.delete();
        model_check = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit r, f;
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 15) == 0);
            cycle(r, f, bit'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  bit'($urandom_range(0, 1)));
        end
        // Drain to confirm nothing is left behind or duplicated.
        for (int n = 0; n < DEPTH + 1; n++) cycle(0, 0, 0, 32'h0, 32'h0, 1);
        check("drained count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling queue between the instruction fetch unit and the decode stage. Captures each fetched (pc, instruction) pair from the fetch side through a valid/ready handshake, holds up to DEPTH pairs in order, and presents them to decode through a second valid/ready handshake. Supports a single-cycle flush, issued on branch or jump redirect, that discards all held pairs.

## Interface
Parameters:
- XLEN, 32, width of pc.
- DEPTH, 2, number of entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries; takes effect at the next edge.
- in_valid  in  1  fetch side presents a pair.
- in_ready  out  1  queue can accept a pair.
- in_pc  in  XLEN  pc of the presented instruction.
- in_inst  in  32  instruction word.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode consumes the head entry.
- out_pc  out  XLEN  pc of the head entry.
- out_inst  out  32  instruction of the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries, each holding {pc, inst}. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = !rst & !flush & (count != DEPTH). in_ready depends only on registered state, rst and flush. It has no combinational path from out_ready.
- out_valid = !flush & (count != 0).
- out_pc and out_inst always equal entry[rd_ptr]. There is no bypass from in_* to out_*.
- On push: entry[wr_ptr] <= {in_pc, in_inst}; wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full (count == DEPTH): in_ready=0. A pop in the same cycle does not enable a push; the push becomes possible the following cycle.
- Empty (count == 0): out_valid=0. A push in the same cycle is not visible at the output until the next cycle.
- Flush: at the edge where flush=1:
  - count, wr_ptr and rd_ptr are set to 0.
  - Entry contents are left as-is (don't-care).
  - Because in_ready=0 and out_valid=0 during the flush cycle, no handshake completes in that cycle.
  - Flush held for several cycles keeps the queue empty.
- rst has priority over flush.
- While out_valid=1 and out_ready=0, out_pc and out_inst stay stable, and out_valid does not drop unless flush or rst is asserted.
- Ordering: pairs leave in exactly the order accepted. There is no duplication and no loss except on flush or rst.

## Timing
- Reset: while rst=1, at each edge count=0, wr_ptr=0, rd_ptr=0, and all entries are cleared to 0. Outputs during and after reset:
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
  - out_valid=0.
  - out_pc=0 and out_inst=0.
  - count=0.
- Latency: a pair pushed at edge N appears on out_* with out_valid=1 in the cycle after edge N (minimum 1 cycle).
- Throughput: 1 pair per cycle in steady state when 0 < count < DEPTH and both sides are always ready and valid.
- Reset asserted mid-operation discards all entries exactly as flush does.
- count is a registered value and reflects the state after the most recent edge.

## Test plan
- Reset then fill: hold rst 2 cycles, check in_ready=0 and out_valid=0. Release rst and push pc=0x0, 0x4 (inst 0x00000013, 0x00100093) with out_ready=0. Required: count=2, in_ready=0, out_pc=0x0 held stable.
- Streaming: out_ready=1 and in_valid=1 every cycle, 8 sequential pcs from 0x100. Required: out_pc sequence 0x100…0x11C in order, one per cycle after the first-cycle latency, count stays at 1.
- Full with simultaneous pop: count=2, in_valid=1, out_ready=1. Required: in_ready=0 that cycle, pop completes, count=1. Next cycle the push is accepted.
- Flush: count=2, assert flush for 1 cycle with in_valid=1 and out_ready=1. Required: in_ready=0 and out_valid=0 during flush, count=0 after the edge. A pc=0x200 pushed in the next cycle is the next output.
- Wrap-around: with DEPTH=2, 5 push/pop rounds at random out_ready. Required: pointer wrap preserves order and the scoreboard matches all pcs.
- Reset mid-operation: rst=1 with count=1. Required: count=0, out_valid=0, out_pc=0 after the edge.
